// File: rtl/fetch_port_arbiter.sv
// Two-core fetch arbiter: round-robin token grant onto one shared instruction port,
// with an in-order tracking FIFO that steers responses back and drops flushed ones.
module fetch_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_WIDTH      = 32,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0][31:0]      req_addr,
  output logic [1:0]            req_grant,
  input  logic [1:0]            flush,
  output logic [1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [CW-1:0]         outstanding,
  output logic                  protocol_error
);

  logic                       token_q, token_d;
  logic [MAX_OUTSTANDING-1:0] id_q, id_d;
  logic [MAX_OUTSTANDING-1:0] killed_q, killed_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       perr_q, perr_d;

  logic [1:0] elig_s;
  logic       winner_s;
  logic       push_s;
  logic       pop_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;
  logic       head_id_s;
  logic       head_killed_s;

  // Pointers wrap at MAX_OUTSTANDING, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUTSTANDING - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign fifo_full_s   = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty_s  = (count_q == {CW{1'b0}});
  assign head_id_s     = id_q[rd_ptr_q];
  assign head_killed_s = killed_q[rd_ptr_q];

  // Eligibility per core; nothing is eligible while in reset.
  always_comb begin
    elig_s = 2'b00;
    if (rst) begin
      elig_s = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        elig_s[i] = req_valid[i] & ~flush[i] & mem_ready & ~fifo_full_s;
      end
    end
  end

  // Grant selection and shared-port drive.
  always_comb begin
    req_grant = 2'b00;
    winner_s  = 1'b0;
    case (elig_s)
      2'b01: begin
        winner_s  = 1'b0;
        req_grant = 2'b01;
      end
      2'b10: begin
        winner_s  = 1'b1;
        req_grant = 2'b10;
      end
      2'b11: begin
        winner_s  = token_q;
        req_grant = token_q ? 2'b10 : 2'b01;
      end
      default: begin
        winner_s  = 1'b0;
        req_grant = 2'b00;
      end
    endcase
    mem_req = |req_grant;
    if (mem_req) begin
      mem_addr = req_addr[winner_s];
    end else begin
      mem_addr = 32'h0000_0000;
    end
  end

  assign push_s = mem_req;
  assign pop_s  = ~rst & mem_resp_valid & ~fifo_empty_s;

  // Response steering; a same-cycle flush of the head's core drops it too.
  always_comb begin
    resp_valid = 2'b00;
    if (pop_s && !head_killed_s && !flush[head_id_s]) begin
      resp_valid[head_id_s] = 1'b1;
    end else begin
      resp_valid = 2'b00;
    end
    if (mem_resp_valid) begin
      resp_data = mem_resp_data;
    end else begin
      resp_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Next-state for token, FIFO contents, pointers, occupancy and error flag.
  always_comb begin
    id_d     = id_q;
    killed_d = killed_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    for (int k = 0; k < MAX_OUTSTANDING; k++) begin
      killed_d[k] = killed_q[k] | flush[id_q[k]];
    end
    if (push_s) begin
      token_d            = ~winner_s;
      id_d[wr_ptr_q]     = winner_s;
      killed_d[wr_ptr_q] = 1'b0;
      wr_ptr_d           = ptr_inc(wr_ptr_q);
    end else begin
      token_d = token_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    perr_d = perr_q | (mem_resp_valid & fifo_empty_s);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      token_q  <= 1'b0;
      id_q     <= {MAX_OUTSTANDING{1'b0}};
      killed_q <= {MAX_OUTSTANDING{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      perr_q   <= 1'b0;
    end else begin
      token_q  <= token_d;
      id_q     <= id_d;
      killed_q <= killed_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      perr_q   <= perr_d;
    end
  end

  assign outstanding    = count_q;
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Directed bench: one arbiter with 8-deep tracking for contention, one with 2-deep for the rest.
module tb_fetch_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_addr;
  logic [1:0]       flush;
  logic             mem_ready;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;

  logic [1:0]  g2, rv2, g8, rv8;
  logic [31:0] rd2, rd8, ma2, ma8;
  logic        mr2, mr8, pe2, pe8;
  logic [1:0]  out2;
  logic [3:0]  out8;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  fetch_port_arbiter #(.MAX_OUTSTANDING(2), .DATA_WIDTH(32)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_grant(g2),
    .flush(flush), .resp_valid(rv2), .resp_data(rd2), .mem_req(mr2), .mem_addr(ma2),
    .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .outstanding(out2), .protocol_error(pe2));

  fetch_port_arbiter #(.MAX_OUTSTANDING(8), .DATA_WIDTH(32)) dut8 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_grant(g8),
    .flush(flush), .resp_valid(rv8), .resp_data(rd8), .mem_req(mr8), .mem_addr(ma8),
    .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .outstanding(out8), .protocol_error(pe8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid      = 2'b00;
    flush          = 2'b00;
    mem_ready      = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    req_addr[0]    = 32'h0;
    req_addr[1]    = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid      = 2'b11;
    mem_resp_valid = 1'b1;
    #2;
    tests_run++;
    if (g2 !== 2'b00 || g8 !== 2'b00 || mr2 !== 1'b0 || rv2 !== 2'b00 || rv8 !== 2'b00) begin
      fails++;
      $display("FAIL reset_ignore_inputs: grant %b/%b mem_req %b resp %b/%b, want all zero", g2, g8, mr2, rv2, rv8);
    end
    tick();
    tick();
    tests_run++;
    if (out2 !== 2'd0 || out8 !== 4'd0 || pe2 !== 1'b0 || pe8 !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: outstanding %0d/%0d perr %b/%b, want 0/0 0/0", out2, out8, pe2, pe8);
    end
    rst = 1'b0;
    idle_inputs();
    #2;
    tests_run++;
    if (g2 !== 2'b00 || mr2 !== 1'b0 || ma2 !== 32'h0) begin
      fails++;
      $display("FAIL reset_idle: grant %b mem_req %b addr %h, want 00 0 0", g2, mr2, ma2);
    end
    tick();
  endtask

  task automatic test_contention();
    logic [1:0]  eg, er;
    logic [31:0] ea;
    req_addr[0] = 32'h0000_1000;
    req_addr[1] = 32'h0000_2000;
    for (int c = 0; c < 5; c++) begin
      req_valid      = (c < 4) ? 2'b11 : 2'b00;
      mem_resp_valid = (c > 0);
      mem_resp_data  = 32'hC0DE_0000 + c;
      eg = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      er = (c == 0) ? 2'b00 : (((c - 1) % 2 == 0) ? 2'b01 : 2'b10);
      ea = (eg == 2'b01) ? 32'h0000_1000 : ((eg == 2'b10) ? 32'h0000_2000 : 32'h0);
      #2;
      tests_run++;
      if (g8 !== eg || ma8 !== ea || g2 !== eg) begin
        fails++;
        $display("FAIL contention_grant_c%0d: grant8 %b grant2 %b addr %h, want %b %h", c, g8, g2, ma8, eg, ea);
      end
      tests_run++;
      if (rv8 !== er || rv2 !== er || (c > 0 && rd8 !== 32'hC0DE_0000 + c)) begin
        fails++;
        $display("FAIL contention_resp_c%0d: resp8 %b resp2 %b data %h, want %b", c, rv8, rv2, rd8, er);
      end
      tick();
    end
    idle_inputs();
    #2;
    tests_run++;
    if (out8 !== 4'd0 || out2 !== 2'd0) begin
      fails++;
      $display("FAIL contention_drain: outstanding %0d/%0d, want 0", out8, out2);
    end
  endtask

  task automatic test_backpressure();
    idle_inputs();
    req_valid   = 2'b01;
    req_addr[0] = 32'h0000_0040;
    for (int c = 0; c < 3; c++) begin
      #2;
      tests_run++;
      if (g2 !== ((c < 2) ? 2'b01 : 2'b00)) begin
        fails++;
        $display("FAIL bp_grant_c%0d: grant %b, want %b", c, g2, (c < 2) ? 2'b01 : 2'b00);
      end
      tick();
    end
    tests_run++;
    if (out2 !== 2'd2) begin
      fails++;
      $display("FAIL bp_full: outstanding %0d, want 2", out2);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_0055;
    #2;
    tests_run++;
    if (rv2 !== 2'b01 || rd2 !== 32'h0000_0055 || g2 !== 2'b00) begin
      fails++;
      $display("FAIL bp_pop: resp %b data %h grant %b, want 01 00000055 00", rv2, rd2, g2);
    end
    tick();
    mem_resp_valid = 1'b0;
    #2;
    tests_run++;
    if (g2 !== 2'b01 || out2 !== 2'd1) begin
      fails++;
      $display("FAIL bp_regrant: grant %b outstanding %0d, want 01 1", g2, out2);
    end
    tick();
    req_valid      = 2'b00;
    mem_resp_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2;
      tests_run++;
      if (rv2 !== 2'b01) begin
        fails++;
        $display("FAIL bp_drain_%0d: resp %b, want 01", c, rv2);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_flush_kill();
    idle_inputs();
    req_valid   = 2'b10;
    req_addr[1] = 32'h0000_0100;
    #2;
    tests_run++;
    if (g2 !== 2'b10 || ma2 !== 32'h0000_0100) begin
      fails++;
      $display("FAIL flush_grant1: grant %b addr %h, want 10 00000100", g2, ma2);
    end
    tick();
    req_valid   = 2'b01;
    req_addr[0] = 32'h0000_0200;
    #2;
    tests_run++;
    if (g2 !== 2'b01 || ma2 !== 32'h0000_0200) begin
      fails++;
      $display("FAIL flush_grant0: grant %b addr %h, want 01 00000200", g2, ma2);
    end
    tick();
    req_valid = 2'b00;
    flush     = 2'b10;
    tick();
    flush          = 2'b00;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_AAAA;
    #2;
    tests_run++;
    if (rv2 !== 2'b00 || rd2 !== 32'h0000_AAAA) begin
      fails++;
      $display("FAIL flush_drop: resp %b data %h, want 00 0000aaaa", rv2, rd2);
    end
    tick();
    mem_resp_data = 32'h0000_BBBB;
    #2;
    tests_run++;
    if (rv2 !== 2'b01 || rd2 !== 32'h0000_BBBB) begin
      fails++;
      $display("FAIL flush_keep: resp %b data %h, want 01 0000bbbb", rv2, rd2);
    end
    tick();
    idle_inputs();
    #2;
    tests_run++;
    if (out2 !== 2'd0) begin
      fails++;
      $display("FAIL flush_empty: outstanding %0d, want 0", out2);
    end
  endtask

  task automatic test_flush_pop_same_cycle();
    idle_inputs();
    req_valid = 2'b01;
    tick();
    req_valid      = 2'b10;
    req_addr[1]    = 32'h0000_0300;
    flush          = 2'b01;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_1111;
    #2;
    tests_run++;
    if (rv2 !== 2'b00 || out2 !== 2'd1 || g2 !== 2'b10 || ma2 !== 32'h0000_0300) begin
      fails++;
      $display("FAIL same_cycle_flush: resp %b out %0d grant %b addr %h, want 00 1 10 00000300", rv2, out2, g2, ma2);
    end
    tick();
    req_valid     = 2'b00;
    flush         = 2'b00;
    mem_resp_data = 32'h0000_2222;
    #2;
    tests_run++;
    if (rv2 !== 2'b10 || out2 !== 2'd1) begin
      fails++;
      $display("FAIL same_cycle_other_core: resp %b out %0d, want 10 1", rv2, out2);
    end
    tick();
    idle_inputs();
    #2;
    tests_run++;
    if (out2 !== 2'd0) begin
      fails++;
      $display("FAIL same_cycle_drain: outstanding %0d, want 0", out2);
    end
  endtask

  task automatic test_flush_blocks_grant();
    idle_inputs();
    req_valid   = 2'b01;
    req_addr[0] = 32'h0000_0400;
    flush       = 2'b01;
    #2;
    tests_run++;
    if (g2 !== 2'b00 || mr2 !== 1'b0 || ma2 !== 32'h0) begin
      fails++;
      $display("FAIL flush_block: grant %b mem_req %b addr %h, want 00 0 0", g2, mr2, ma2);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_spurious_response();
    idle_inputs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEAD_BEEF;
    #2;
    tests_run++;
    if (rv2 !== 2'b00 || pe2 !== 1'b0) begin
      fails++;
      $display("FAIL spurious_comb: resp %b perr %b, want 00 0", rv2, pe2);
    end
    tick();
    mem_resp_valid = 1'b0;
    #2;
    tests_run++;
    if (pe2 !== 1'b1 || out2 !== 2'd0) begin
      fails++;
      $display("FAIL spurious_set: perr %b out %0d, want 1 0", pe2, out2);
    end
    tick();
    tick();
    tests_run++;
    if (pe2 !== 1'b1) begin
      fails++;
      $display("FAIL spurious_sticky: perr %b, want 1", pe2);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    tests_run++;
    if (pe2 !== 1'b0) begin
      fails++;
      $display("FAIL spurious_clear: perr %b, want 0", pe2);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_flush_kill();
    test_flush_pop_same_cycle();
    test_flush_blocks_grant();
    test_spurious_response();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
